pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 The block SHALL have parameter STEP, default 2: sequential PC increment in bytes.
REQ-003 The block SHALL have a single clock; reset is synchronous and active-low.
REQ-004 Port clk  input  1: rising-edge clock for all state.
REQ-005 Port rst_n  input  1: synchronous active-low reset.
REQ-006 Port pc_in  input  16: next-PC value from the PC select mux (pc_plus2 or jump target).
REQ-007 Port redirect  input  1: pc_in is a jump/branch target (same signal as the mux choice).
REQ-008 Port pc_plus2  output  16: sequential next PC, feeds the mux sequential input.
REQ-009 Port imem_req  output  1: instruction memory read request.
REQ-010 Port imem_addr  output  16: instruction memory address.
REQ-011 Port imem_ack  input  1: memory returns imem_data this cycle.
REQ-012 Port imem_data  input  16: instruction word.
REQ-013 Port instr_out  output  16: held instruction to decode.
REQ-014 Port instr_pc  output  16: address of instr_out.
REQ-015 Port instr_valid  output  1: instr_out valid.
REQ-016 Port instr_ready  input  1: decode accepts instr_out this cycle.

Function
REQ-017 pc_plus2 SHALL equal (pc + STEP) mod 2^16, combinational; 16'hFFFE + 2 -> 16'h0000.
REQ-018 imem_addr SHALL equal the current pc register, combinational.
REQ-019 FSM states SHALL be IDLE, FETCH, HOLD; encoding free.
REQ-020 IDLE: imem_req=0; next cycle -> FETCH unconditionally.
REQ-021 FETCH: imem_req=1; imem_ack=1 and redirect=0 -> instr_out<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc_in, -> HOLD.
REQ-022 FETCH with imem_ack=0 SHALL hold pc and remain in FETCH; imem_req stays 1.
REQ-023 HOLD: imem_req=0, instr_valid=1, instr_out/instr_pc stable; instr_ready=1 -> instr_valid<=0, -> FETCH; instr_ready=0 -> stay.
REQ-024 A handshake SHALL complete only on instr_valid & instr_ready; each fetched word SHALL be delivered exactly once.
REQ-025 redirect=1 in any state SHALL load pc<=pc_in, clear instr_valid, and enter FETCH next cycle; it has priority over all other events.
REQ-026 redirect and imem_ack same cycle: fetched word SHALL be discarded, instr_valid<=0.
REQ-027 redirect and instr_ready same cycle in HOLD: handshake counts as complete, pc<=pc_in, -> FETCH.
REQ-028 pc SHALL update only on REQ-021 or REQ-025; pc_in is ignored otherwise.
REQ-029 Throughput: one instruction per 2 cycles minimum (FETCH+HOLD) with zero-wait memory and instr_ready=1.

Reset
REQ-030 rst_n=0 at a rising edge SHALL set pc=RESET_PC, state=IDLE, instr_valid=0, instr_out=0, instr_pc=0; imem_req=0 while in reset.
REQ-031 Reset SHALL override redirect, imem_ack and instr_ready, including mid-FETCH and mid-HOLD; no pending word survives.
REQ-032 First imem_req SHALL assert in the 2nd cycle after rst_n rises (IDLE, then FETCH).

Verification
REQ-033 Reset release, pc_in tied to pc_plus2, ack always 1, ready always 1 -> imem_addr 0000, 0002, 0004 in successive FETCH cycles; instr_pc matches.
REQ-034 Wait states: ack low 3 cycles at pc=0002 -> imem_req held, imem_addr=0002 stable, then instr_out=imem_data, instr_pc=0002.
REQ-035 Back-pressure: ready low 4 cycles in HOLD with instr_out=16'h1234 -> instr_out/instr_valid stable, no new imem_req; ready high -> single handshake.
REQ-036 Redirect: redirect=1, pc_in=007C during FETCH with ack=1 at pc=000E -> word dropped, next imem_addr=007C, instr_valid=0.
REQ-037 Wrap: RESET_PC=16'hFFFE -> pc_plus2=0000, second fetch address 0000.
REQ-038 Reset asserted in HOLD with instr_valid=1 -> next cycle instr_valid=0, pc=RESET_PC, state IDLE.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register plus a three-state fetch sequencer.
// Holds one fetched word until decode takes it.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned STEP     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  input  logic        redirect,
  output logic [15:0] pc_plus2,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_instr_pc;
  logic        r_valid;
  logic [15:0] w_step;

  assign w_step      = 16'(STEP);
  assign pc_plus2    = r_pc + w_step;
  assign imem_addr   = r_pc;
  assign imem_req    = rst_n && (r_state == FETCH);
  assign instr_out   = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;

  // Redirect wins over ack and ready; a word
  // arriving alongside it is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 16'h0000;
      r_instr_pc <= 16'h0000;
      r_valid    <= 1'b0;
    end else if (redirect) begin
      r_pc    <= pc_in;
      r_valid <= 1'b0;
      r_state <= FETCH;
    end else begin
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            r_instr    <= imem_data;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= pc_in;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            r_state <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios
// plus a random run against a transaction model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] tgt = 16'h0000;
  logic        ack = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        ready = 1'b0;
  logic [15:0] pc_in, pc_plus2, imem_addr, instr_out, instr_pc;
  logic        imem_req, instr_valid;

  logic [15:0] w_pc_plus2, w_addr, w_out, w_ipc;
  logic        w_req, w_valid;

  int checks = 0;
  int errors = 0;

  assign pc_in = redirect ? tgt : pc_plus2;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in),
    .redirect(redirect), .pc_plus2(pc_plus2),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(ack), .imem_data(data),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(ready)
  );

  pc_fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .pc_in(w_pc_plus2),
    .redirect(1'b0), .pc_plus2(w_pc_plus2),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(1'b1), .imem_data(16'hA5A5),
    .instr_out(w_out), .instr_pc(w_ipc),
    .instr_valid(w_valid), .instr_ready(1'b1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0;
    ack = 1'b0; ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b1; tgt = 16'h0040;
    ack = 1'b1; ready = 1'b1; data = 16'hBEEF;
    step(); step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got %b exp 0", imem_req);
    end
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 16'h0
        || instr_pc !== 16'h0) begin
      errors++;
      $display("FAIL rst_out got %b %h %h exp 0 0 0",
               instr_valid, instr_out, instr_pc);
    end
    checks++;
    if (imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL rst_pc got %h exp 0000", imem_addr);
    end
    redirect = 1'b0; ack = 1'b0; ready = 1'b0;
    rst_n = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req got %b exp 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL first_req got %b %h exp 1 0000",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] d;
    do_reset(); step();
    ack = 1'b1; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      data = d;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(i * 2)) begin
        errors++;
        $display("FAIL seq_addr%0d got %b %h exp 1 %h",
                 i, imem_req, imem_addr, 16'(i * 2));
      end
      checks++;
      if (pc_plus2 !== 16'(i * 2 + 2)) begin
        errors++;
        $display("FAIL seq_plus2 got %h exp %h",
                 pc_plus2, 16'(i * 2 + 2));
      end
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'(i * 2)
          || instr_out !== d || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL seq_hold%0d got %b %h %h exp 1 %h %h",
                 i, instr_valid, instr_pc, instr_out,
                 16'(i * 2), d);
      end
      step();
    end
  endtask

  task automatic test_wait_backpressure();
    do_reset(); step();
    ack = 1'b1; ready = 1'b1; data = 16'h1111;
    step(); step();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
        errors++;
        $display("FAIL wait%0d got %b %h exp 1 0002",
                 i, imem_req, imem_addr);
      end
      step();
    end
    ack = 1'b1; data = 16'h5A5A;
    step();
    checks++;
    if (instr_out !== 16'h5A5A || instr_pc !== 16'h0002
        || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_word got %h %h %b exp 5a5a 0002 1",
               instr_out, instr_pc, instr_valid);
    end
    step();
    data = 16'h1234; ready = 1'b0;
    step();
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 16'h1234
          || instr_pc !== 16'h0004 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL bp%0d got %b %h %h %b exp 1 1234 0004 0",
                 i, instr_valid, instr_out, instr_pc, imem_req);
      end
      step();
    end
    ready = 1'b1; ack = 1'b0;
    step();
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1
        || imem_addr !== 16'h0006) begin
      errors++;
      $display("FAIL bp_hs got %b %b %h exp 0 1 0006",
               instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect();
    do_reset(); step();
    ack = 1'b1; ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(); step();
    end
    redirect = 1'b1; tgt = 16'h007C; data = 16'hDEAD;
    checks++;
    if (imem_addr !== 16'h000E || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redir_pre got %h %b exp 000e 1",
               imem_addr, imem_req);
    end
    step();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 16'h007C
        || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redir got %b %h %b exp 0 007c 1",
               instr_valid, imem_addr, imem_req);
    end
    data = 16'h7777;
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h007C
        || instr_out !== 16'h7777) begin
      errors++;
      $display("FAIL redir_word got %b %h %h exp 1 007c 7777",
               instr_valid, instr_pc, instr_out);
    end
    redirect = 1'b1; tgt = 16'h0100;
    step();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 16'h0100
        || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redir_hold got %b %h %b exp 0 0100 1",
               instr_valid, imem_addr, imem_req);
    end
  endtask

  task automatic test_reset_hold();
    do_reset(); step();
    ack = 1'b1; ready = 1'b0; data = 16'h4242;
    step(); step();
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL rh_pre got %b exp 1", instr_valid);
    end
    rst_n = 1'b0; ready = 1'b1; redirect = 1'b1; tgt = 16'h0300;
    step();
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 16'h0000
        || imem_req !== 1'b0 || instr_out !== 16'h0) begin
      errors++;
      $display("FAIL rh got %b %h %b %h exp 0 0000 0 0000",
               instr_valid, imem_addr, imem_req, instr_out);
    end
    rst_n = 1'b1; redirect = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000
        || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rh_rel got %b %h %b exp 1 0000 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++;
    if (w_addr !== 16'hFFFE || w_pc_plus2 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_rst got %h %h exp fffe 0000",
               w_addr, w_pc_plus2);
    end
    step(); step(); step();
    checks++;
    if (w_req !== 1'b1 || w_addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_2nd got %b %h exp 1 0000",
               w_req, w_addr);
    end
  endtask

  task automatic test_random(input int n);
    logic [15:0] exp_addr, pend_d, pend_a;
    bit          pend;
    int          bad;
    do_reset(); step();
    exp_addr = 16'h0000; pend = 1'b0;
    pend_d = 16'h0; pend_a = 16'h0;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      ack      = ($urandom_range(3) != 0);
      ready    = ($urandom_range(2) != 0);
      redirect = ($urandom_range(9) == 0);
      tgt      = 16'($urandom) & 16'hFFFE;
      data     = 16'($urandom);
      checks++;
      if (instr_valid !== pend || imem_req !== !pend) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rnd_state c%0d got v%b r%b exp v%b",
                   i, instr_valid, imem_req, pend);
      end
      checks++;
      if (!pend && (imem_addr !== exp_addr
          || pc_plus2 !== 16'(exp_addr + 16'd2))) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rnd_addr c%0d got %h %h exp %h",
                   i, imem_addr, pc_plus2, exp_addr);
      end
      checks++;
      if (pend && (instr_out !== pend_d
          || instr_pc !== pend_a)) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rnd_word c%0d got %h@%h exp %h@%h",
                   i, instr_out, instr_pc, pend_d, pend_a);
      end
      if (redirect) begin
        pend = 1'b0;
        exp_addr = tgt;
      end else if (!pend && ack) begin
        pend = 1'b1;
        pend_d = data;
        pend_a = exp_addr;
        exp_addr = exp_addr + 16'd2;
      end else if (pend && ready) begin
        pend = 1'b0;
      end
      step();
    end
    redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_backpressure();
    test_redirect();
    test_reset_hold();
    test_wrap();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
